// File: rtl/alarm_sequencer_pkg.sv
// alarm_sequencer_pkg: shared state encodings and time field widths for the clock alarm path
package alarm_sequencer_pkg;
  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RINGING = 2'd2;
  localparam logic [1:0] ST_SNOOZE = 2'd3;
  localparam int HRS_W = 4;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
endpackage

// File: rtl/alarm_sequencer_tone_gen.sv
// tone_gen: free-running half-period divider producing the buzzer square wave
module tone_gen #(
  parameter int HALF_PERIOD = 10_000
) (
  input  logic video_clk,
  input  logic reset,
  output logic tone_sq
);
  localparam int W = (HALF_PERIOD < 2) ? 1 : $clog2(HALF_PERIOD);
  localparam logic [W-1:0] LAST = W'(HALF_PERIOD - 1);
  logic [W-1:0] cnt;
  // count to the terminal value, flip the square wave and wrap; runs in every alarm state
  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      tone_sq <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      tone_sq <= ~tone_sq;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm arm/ring/snooze controller gating a square tone onto the buzzer pin
module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int CLK_HZ = 31_500_000,
  parameter int TONE_HZ = 1575,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S = 300
) (
  input  logic             video_clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             sec_phase,
  input  logic [HRS_W-1:0] hours,
  input  logic [MIN_W-1:0] minutes,
  input  logic [HRS_W-1:0] al_hours,
  input  logic [MIN_W-1:0] al_minutes,
  input  logic             toggle_pulse,
  input  logic             snooze_pulse,
  output logic             al_on,
  output logic             ringing,
  output logic             snoozing,
  output logic             buzzer_out
);
  localparam int HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int RW = $clog2(RING_TIMEOUT_S + 1);
  localparam int SW = $clog2(SNOOZE_S + 1);
  localparam logic [RW-1:0] RING_LOAD = RW'(RING_TIMEOUT_S);
  localparam logic [SW-1:0] SNZ_LOAD = SW'(SNOOZE_S);
  logic [1:0] state;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic match, match_d, trigger, tone_sq;
  tone_gen #(.HALF_PERIOD(HALF)) u_tone (
    .video_clk(video_clk),
    .reset(reset),
    .tone_sq(tone_sq)
  );
  // out-of-range time values are compared raw; normalisation belongs to the time registers
  assign match = (hours == al_hours) && (minutes == al_minutes);
  assign trigger = match & ~match_d;
  // remember last cycle's match so only entry into the alarm minute rings
  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) match_d <= 1'b0;
    else match_d <= match;
  end
  // alarm FSM with both countdowns; priority toggle > snooze > tick > trigger
  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) begin
      state <= ST_OFF;
      ring_cnt <= '0;
      snz_cnt <= '0;
    end else if (toggle_pulse) begin
      state <= (state == ST_OFF) ? ST_ARMED : ST_OFF;
    end else begin
      case (state)
        ST_ARMED:
          if (trigger) begin
            state <= ST_RINGING;
            ring_cnt <= RING_LOAD;
          end
        ST_RINGING:
          if (snooze_pulse) begin
            state <= ST_SNOOZE;
            snz_cnt <= SNZ_LOAD;
          end else if (tick_1hz) begin
            ring_cnt <= ring_cnt - 1'b1;
            if (ring_cnt == RW'(1)) state <= ST_ARMED;
          end
        ST_SNOOZE:
          if (tick_1hz) begin
            snz_cnt <= snz_cnt - 1'b1;
            if (snz_cnt == SW'(1)) begin
              state <= ST_RINGING;
              ring_cnt <= RING_LOAD;
            end
          end
        default: ;
      endcase
    end
  end
  // registered buzzer: tone gated to the first half of each second while ringing
  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) buzzer_out <= 1'b0;
    else buzzer_out <= (state == ST_RINGING) & sec_phase & tone_sq;
  end
  assign al_on = state != ST_OFF;
  assign ringing = state == ST_RINGING;
  assign snoozing = state == ST_SNOOZE;
endmodule
